// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port RAM.
// Fixed four-cycle transaction: IDLE -> ACCESS -> CAPTURE -> ACK.
`timescale 1ns/1ps
`default_nettype none

module mem_arbiter #(
  parameter int            AW    = 9,
  parameter int            DW    = 12,
  parameter logic [AW-1:0] LIMIT = 9'h1F8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          p0_req,
  input  logic          p0_rw,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic          p1_rw,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          mem_cs,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout,
  output logic [1:0]    gnt,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_owner;
  logic          r_last;
  logic          r_rw;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          w_any;
  logic          w_win;
  logic          w_in_ram;
  logic [DW-1:0] w_cap;

  assign w_any    = p0_req | p1_req;
  assign w_in_ram = (r_addr < LIMIT);
  assign w_cap    = (r_rw && w_in_ram) ? mem_dout : '0;

  always_comb begin
    w_next = r_state;
    w_win  = 1'b0;
    case (r_state)
      IDLE: begin
        // On contention the port that was not granted last wins.
        w_win = (p0_req && p1_req) ? ~r_last : p1_req;
        if (w_any) w_next = ACCESS;
      end
      ACCESS:  w_next = CAPTURE;
      CAPTURE: w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_rw     <= 1'b1;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_owner <= w_win;
        r_last  <= w_win;
        r_rw    <= w_win ? p1_rw    : p0_rw;
        r_addr  <= w_win ? p1_addr  : p0_addr;
        r_wdata <= w_win ? p1_wdata : p0_wdata;
      end
      if (r_state == CAPTURE) begin
        if (r_owner) r_rdata1 <= w_cap;
        else         r_rdata0 <= w_cap;
      end
    end
  end

  assign mem_cs   = (r_state == ACCESS) && w_in_ram;
  assign mem_rw   = (r_state == ACCESS) ? r_rw : 1'b1;
  assign mem_addr = r_addr;
  assign mem_din  = r_wdata;
  assign p0_ack   = (r_state == ACK) && !r_owner;
  assign p1_ack   = (r_state == ACK) &&  r_owner;
  assign p0_rdata = r_rdata0;
  assign p1_rdata = r_rdata1;
  assign busy     = (r_state != IDLE);
  assign gnt      = (r_state == IDLE) ? 2'b00 : (r_owner ? 2'b10 : 2'b01);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, hand sequences and a randomized run
// against a transaction-level reference model of the arbiter.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;
  localparam int            AW    = 9;
  localparam int            DW    = 12;
  localparam logic [AW-1:0] LIMIT = 9'h1F8;

  logic          clk = 1'b0;
  logic          rstn;
  logic          p0_req, p0_rw, p1_req, p1_rw;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack, p1_ack;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_cs, mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic [1:0]    gnt;
  logic          busy;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .LIMIT(LIMIT)) dut (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_cs(mem_cs), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .gnt(gnt), .busy(busy)
  );

  // Environment RAM: registered read, preload port for test setup.
  logic [DW-1:0] ram [0:511];
  logic [DW-1:0] r_dout;
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  assign mem_dout = r_dout;
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_cs) begin
      if (!mem_rw) ram[mem_addr] <= mem_din;
      else         r_dout <= ram[mem_addr];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " gnt"},      32'(gnt),      32'd0);
    chk({tag, " busy"},     32'(busy),     32'd0);
    chk({tag, " mem_cs"},   32'(mem_cs),   32'd0);
    chk({tag, " mem_rw"},   32'(mem_rw),   32'd1);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, " mem_din"},  32'(mem_din),  32'd0);
    chk({tag, " p0_ack"},   32'(p0_ack),   32'd0);
    chk({tag, " p1_ack"},   32'(p1_ack),   32'd0);
    chk({tag, " p0_rdata"}, 32'(p0_rdata), 32'd0);
    chk({tag, " p1_rdata"}, 32'(p1_rdata), 32'd0);
  endtask

  // One isolated transaction; returns latency in cycles from the IDLE cycle.
  task automatic run_txn(input logic port, input logic rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, output int lat,
                         output logic [DW-1:0] rd, output int cs_n,
                         output logic rw_seen, output int other_acks);
    int g = 0;
    while (busy && g < 10) begin tick(); g++; end
    if (port) begin p1_req = 1'b1; p1_rw = rw; p1_addr = a; p1_wdata = wd; end
    else      begin p0_req = 1'b1; p0_rw = rw; p0_addr = a; p0_wdata = wd; end
    lat = -1; rd = '0; cs_n = 0; rw_seen = 1'b1; other_acks = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (mem_cs) cs_n++;
      rw_seen = rw_seen & mem_rw;
      if (port ? p0_ack : p1_ack) other_acks++;
      if (port ? p1_ack : p0_ack) begin
        lat = c;
        rd  = port ? p1_rdata : p0_rdata;
        break;
      end
    end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  typedef struct {
    logic          port;
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            cs_n;
    logic [DW-1:0] rd;
  } vec_t;

  // Reference model state (transaction level)
  logic [DW-1:0] gold [0:511];
  int            m_t;
  logic          m_own, m_last, m_rw;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_exp;
  logic [DW-1:0] m_rd [2];

  task automatic model_step();
    logic w;
    if (m_t == 0) begin
      if (p0_req || p1_req) begin
        w      = (p0_req && p1_req) ? !m_last : p1_req;
        m_own  = w;
        m_last = w;
        m_rw   = w ? p1_rw    : p0_rw;
        m_addr = w ? p1_addr  : p0_addr;
        m_wd   = w ? p1_wdata : p0_wdata;
        m_exp  = '0;
        if (m_addr < LIMIT) begin
          if (m_rw) m_exp = gold[m_addr];
          else      gold[m_addr] = m_wd;
        end
        m_t = 1;
      end
    end else if (m_t == 3) begin
      m_t = 0;
    end else begin
      m_t++;
      if (m_t == 3) m_rd[m_own] = m_exp;
    end
  endtask

  logic          rq [2];
  logic          rrw [2];
  logic [AW-1:0] raddr [2];
  logic [DW-1:0] rwd [2];

  task automatic new_fields(input int i);
    rrw[i]   = 1'($urandom_range(0, 1));
    raddr[i] = ($urandom_range(0, 3) == 0) ? AW'(9'h1F0 + 9'($urandom_range(0, 15)))
                                           : AW'($urandom_range(0, 31));
    rwd[i]   = DW'($urandom);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vec_t          tbl [9];
    int            lat, cs_n, oth;
    logic [DW-1:0] rd;
    logic          rws;
    logic [DW-1:0] last_rd [2];

    tbl[0] = '{1'b0, 1'b1, 9'h010, 12'h000, 1, 12'h5A3};
    tbl[1] = '{1'b1, 1'b0, 9'h020, 12'hABC, 1, 12'h000};
    tbl[2] = '{1'b0, 1'b1, 9'h020, 12'h000, 1, 12'hABC};
    tbl[3] = '{1'b0, 1'b1, 9'h1FC, 12'h000, 0, 12'h000};
    tbl[4] = '{1'b1, 1'b0, 9'h1F8, 12'h111, 0, 12'h000};
    tbl[5] = '{1'b1, 1'b1, 9'h1F7, 12'h000, 1, 12'h7E1};
    tbl[6] = '{1'b0, 1'b0, 9'h1F7, 12'h222, 1, 12'h000};
    tbl[7] = '{1'b1, 1'b1, 9'h1F7, 12'h000, 1, 12'h222};
    tbl[8] = '{1'b0, 1'b1, 9'h1F8, 12'h000, 0, 12'h000};

    rstn = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    p0_req = 0; p0_rw = 1; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_rw = 1; p1_addr = '0; p1_wdata = '0;
    preload(9'h010, 12'h5A3);
    preload(9'h1F7, 12'h7E1);
    preload(9'h1F8, 12'h000);
    chk_reset_outputs("reset");
    rstn = 1'b1;
    tick();

    last_rd[0] = '0; last_rd[1] = '0;
    foreach (tbl[k]) begin
      run_txn(tbl[k].port, tbl[k].rw, tbl[k].addr, tbl[k].wd, lat, rd, cs_n, rws, oth);
      chk($sformatf("vec%0d latency", k), 32'(lat), 32'd3);
      chk($sformatf("vec%0d rdata", k), 32'(rd), 32'(tbl[k].rd));
      chk($sformatf("vec%0d cs_pulses", k), 32'(cs_n), 32'(tbl[k].cs_n));
      chk($sformatf("vec%0d mem_rw", k), 32'(rws), 32'(tbl[k].rw));
      chk($sformatf("vec%0d other_ack", k), 32'(oth), 32'd0);
      chk($sformatf("vec%0d other_rdata_hold", k),
          32'(tbl[k].port ? p0_rdata : p1_rdata), 32'(last_rd[!tbl[k].port]));
      last_rd[tbl[k].port] = tbl[k].rd;
    end

    // Simultaneous requests from reset: p0 first, then strict alternation.
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    p0_req = 1; p0_rw = 1; p0_addr = 9'h010;
    p1_req = 1; p1_rw = 1; p1_addr = 9'h020;
    for (int c = 1; c <= 16; c++) begin
      tick();
      chk($sformatf("rr p0_ack c%0d", c), 32'(p0_ack), 32'(c == 3 || c == 11));
      chk($sformatf("rr p1_ack c%0d", c), 32'(p1_ack), 32'(c == 7 || c == 15));
      if (c == 3) chk("rr p0_rdata", 32'(p0_rdata), 32'h5A3);
      if (c == 7) chk("rr p1_rdata", 32'(p1_rdata), 32'hABC);
    end
    p0_req = 0; p1_req = 0;

    // Reset during CAPTURE of a p1 read; held request restarts cleanly.
    tick();
    p1_req = 1; p1_rw = 1; p1_addr = 9'h010;
    tick();
    tick();
    chk("abort busy before reset", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    chk_reset_outputs("abort");
    tick();
    rstn = 1'b1;
    begin
      int l = -1;
      for (int c = 1; c <= 8; c++) begin
        tick();
        if (p0_ack) chk("abort stray p0_ack", 32'd1, 32'd0);
        if (p1_ack) begin l = c; break; end
      end
      chk("abort restart latency", 32'(l), 32'd3);
      chk("abort restart rdata", 32'(p1_rdata), 32'h5A3);
    end
    p1_req = 0;

    // Randomized run against the reference model.
    tick();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    for (int a = 0; a < 512; a++) gold[a] = ram[a];
    m_t = 0; m_own = 0; m_last = 1; m_rw = 1; m_addr = '0; m_wd = '0; m_exp = '0;
    m_rd[0] = '0; m_rd[1] = '0;
    for (int i = 0; i < 2; i++) begin rq[i] = 0; new_fields(i); end
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      chk("rnd gnt", 32'(gnt), (m_t != 0) ? (m_own ? 32'd2 : 32'd1) : 32'd0);
      chk("rnd busy", 32'(busy), 32'(m_t != 0));
      chk("rnd mem_cs", 32'(mem_cs), 32'(m_t == 1 && m_addr < LIMIT));
      chk("rnd mem_rw", 32'(mem_rw), (m_t == 1) ? 32'(m_rw) : 32'd1);
      chk("rnd p0_ack", 32'(p0_ack), 32'(m_t == 3 && !m_own));
      chk("rnd p1_ack", 32'(p1_ack), 32'(m_t == 3 && m_own));
      chk("rnd p0_rdata", 32'(p0_rdata), 32'(m_rd[0]));
      chk("rnd p1_rdata", 32'(p1_rdata), 32'(m_rd[1]));
      if (m_t != 0) begin
        chk("rnd mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("rnd mem_din", 32'(mem_din), 32'(m_wd));
      end
      for (int i = 0; i < 2; i++) begin
        logic mine;
        mine = (m_t != 0) && (m_own == 1'(i));
        if (!rq[i]) begin
          if ($urandom_range(0, 2) == 0) begin rq[i] = 1; new_fields(i); end
        end else if (mine && m_t == 3) begin
          if ($urandom_range(0, 1) == 0) rq[i] = 0;
          else new_fields(i);
        end else if (mine) begin
          new_fields(i);
          if ($urandom_range(0, 7) == 0) rq[i] = 0;
        end
      end
      p0_req = rq[0]; p0_rw = rrw[0]; p0_addr = raddr[0]; p0_wdata = rwd[0];
      p1_req = rq[1]; p1_rw = rrw[1]; p1_addr = raddr[1]; p1_wdata = rwd[1];
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, default 9, address width.
REQ-002 Parameter DW, default 12, data width.
REQ-003 Parameter LIMIT, default 9'h1F8; addresses >= LIMIT are peripheral space and are not forwarded to RAM.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-low, ports clk and rstn.
REQ-005 clk  input  1  system clock, all state on rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 p0_req  input  1  port 0 (CPU) request; held high until p0_ack.
REQ-008 p0_rw  input  1  port 0 direction, 1=read, 0=write.
REQ-009 p0_addr  input  AW  port 0 address.
REQ-010 p0_wdata  input  DW  port 0 write data.
REQ-011 p0_ack  output  1  port 0 one-cycle completion pulse.
REQ-012 p0_rdata  output  DW  port 0 read data, valid while p0_ack=1.
REQ-013 p1_req, p1_rw, p1_addr, p1_wdata, p1_ack, p1_rdata: port 1 (serial loader), same widths and meaning as port 0.
REQ-014 mem_cs  output  1  RAM chip select.
REQ-015 mem_rw  output  1  RAM direction, 1=read, 0=write.
REQ-016 mem_addr  output  AW  RAM address.
REQ-017 mem_din  output  DW  RAM write data.
REQ-018 mem_dout  input  DW  RAM read data, registered in RAM, valid one cycle after mem_cs.
REQ-019 gnt  output  2  one-hot owner of current transaction, 00 when idle.
REQ-020 busy  output  1  high whenever state is not IDLE.

Function
REQ-021 FSM states IDLE, ACCESS, CAPTURE, ACK; all transitions unconditional except IDLE.
REQ-022 IDLE: no req -> stay; any req high -> select winner, latch its rw/addr/wdata, set gnt, go ACCESS.
REQ-023 Arbitration round-robin: single requester wins; both requesting -> port not granted last wins; pointer updated only on a grant.
REQ-024 ACCESS (1 cycle): mem_cs=1 if latched addr < LIMIT else 0; mem_rw, mem_addr, mem_din from latched values; go CAPTURE.
REQ-025 Outside ACCESS: mem_cs=0, mem_rw=1; mem_addr/mem_din hold latched values.
REQ-026 CAPTURE: read to RAM -> register mem_dout into winner's rdata; write or addr >= LIMIT -> winner's rdata register <= 0; go ACK.
REQ-027 ACK: winner's ack=1 for exactly this cycle, other ack=0; go IDLE, gnt cleared.
REQ-028 Fixed latency: req sampled in IDLE at cycle N -> ack in cycle N+3; back-to-back grants every 4 cycles.
REQ-029 Loser's request stays pending, no ack; served at next IDLE per REQ-023.
REQ-030 Req high in IDLE after its own ack is a new transaction.
REQ-031 Req/addr/data changes after grant ignored (latched at grant); req drop mid-transaction does not abort it.
REQ-032 rdata of non-winning port holds previous value.
REQ-033 Address arithmetic none; LIMIT comparison unsigned, AW bits.

Reset
REQ-034 rstn=0 at any time, including mid-transaction: state IDLE, mem_cs=0, mem_rw=1, mem_addr=0, mem_din=0, p0_ack=p1_ack=0, p0_rdata=p1_rdata=0, gnt=00, busy=0, round-robin pointer favours port 0.
REQ-035 Transaction interrupted by reset is lost; no ack issued after release.

Verification
REQ-036 RAM[0x010]=0x5A3; p0 read 0x010 alone -> mem_cs high 1 cycle, p0_ack cycle N+3, p0_rdata=0x5A3.
REQ-037 p1 write 0x020 data 0xABC then p0 read 0x020 -> mem_rw=0 in p1 ACCESS, p0_rdata=0xABC.
REQ-038 p0 and p1 both request from reset -> p0 acked first, p1 acked 4 cycles later; repeated simultaneous requests alternate p1,p0,...
REQ-039 p0 read addr 0x1FC -> mem_cs never high, p0_ack at N+3, p0_rdata=0x000.
REQ-040 rstn low during CAPTURE of p1 read -> all outputs at reset values immediately, no p1_ack; p1_req held after release -> fresh transaction acked 3 cycles after first IDLE.
